// File: rtl/firewall.sv
// Ethernet receive filter on an RMII dibit stream: forwards the payload of frames
// addressed to MY_MAC or to broadcast, one registered cycle after each input dibit.
module firewall #(
    parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam logic [5:0] LastDest   = 6'd23;
    localparam logic [5:0] LastHeader = 6'd55;

    typedef enum logic [1:0] {
        HEADER,
        PAYLOAD,
        DROP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] headerCnt_q, headerCnt_d;
    logic       mineFlag_q, mineFlag_d;
    logic       bcastFlag_q, bcastFlag_d;
    logic       axiov_q, axiov_d;
    logic [1:0] axiod_q, axiod_d;

    // Station address laid out in wire order, one dibit per header position.
    // Entries past the destination field are padding so the 5-bit index is always legal.
    logic [1:0] macDibit [32];

    for (genvar k = 0; k < 24; k++) begin : g_macDibit
        assign macDibit[k] = MY_MAC[40 - 8*(k/4) + 2*(k%4) +: 2];
    end
    for (genvar k = 24; k < 32; k++) begin : g_macPad
        assign macDibit[k] = 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        headerCnt_d = headerCnt_q;
        mineFlag_d  = mineFlag_q;
        bcastFlag_d = bcastFlag_q;
        axiov_d     = 1'b0;
        axiod_d     = 2'b00;

        if (!axiiv) begin
            // An idle cycle always re-arms the filter for the next frame.
            state_d     = HEADER;
            headerCnt_d = '0;
            mineFlag_d  = 1'b1;
            bcastFlag_d = 1'b1;
        end else begin
            case (state_q)
                HEADER: begin
                    if (headerCnt_q <= LastDest) begin
                        mineFlag_d  = mineFlag_q  & (axiid == macDibit[headerCnt_q[4:0]]);
                        bcastFlag_d = bcastFlag_q & (axiid == 2'b11);
                    end
                    if (headerCnt_q != LastHeader) begin
                        headerCnt_d = headerCnt_q + 6'd1;
                    end
                    if (headerCnt_q == LastDest && !mineFlag_d && !bcastFlag_d) begin
                        state_d = DROP;
                    end else if (headerCnt_q == LastHeader) begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    axiov_d = 1'b1;
                    axiod_d = axiid;
                end
                DROP: begin
                    state_d = DROP;
                end
                default: begin
                    state_d = DROP;
                end
            endcase
        end
    end

    // Reset parks the filter in DROP so a frame already on the wire is never half-forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DROP;
            headerCnt_q <= '0;
            mineFlag_q  <= 1'b1;
            bcastFlag_q <= 1'b1;
            axiov_q     <= 1'b0;
            axiod_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            headerCnt_q <= headerCnt_d;
            mineFlag_q  <= mineFlag_d;
            bcastFlag_q <= bcastFlag_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_firewall.sv
// Self-checking bench for firewall: directed scenarios plus randomized frames,
// all compared cycle by cycle against a frame-level reference model.
module tb_firewall;

    localparam logic [47:0] MAC   = 48'h69_69_5A_06_54_91;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;

    firewall #(.MY_MAC(MAC)) dut (
        .clk  (clk),
        .rst  (rst),
        .axiiv(axiiv),
        .axiid(axiid),
        .axiov(axiov),
        .axiod(axiod)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current frame, whether the frame
    // began after a clean idle cycle, and the captured destination dibits.
    int         mPos   = 0;
    bit         mArmed = 1'b0;
    logic [1:0] mDest [24];

    logic       capOv [$];
    logic [1:0] capOd [$];
    logic       expOv [$];
    logic [1:0] expOd [$];
    logic [1:0] payQ  [$];
    int         firstIdx;
    logic [1:0] fr    [$];

    function automatic bit destOk();
        logic [47:0] a = '0;
        for (int b = 0; b < 6; b++) begin
            a = {a[39:0], mDest[4*b+3], mDest[4*b+2], mDest[4*b+1], mDest[4*b]};
        end
        return (a == MAC) || (a == BCAST);
    endfunction

    task automatic clearCap();
        capOv.delete();
        capOd.delete();
        expOv.delete();
        expOd.delete();
        payQ.delete();
        firstIdx = -1;
    endtask

    task automatic stepCycle(input logic r, input logic v, input logic [1:0] d);
        logic eo;
        rst   = r;
        axiiv = v;
        axiid = d;
        eo    = 1'b0;
        if (r) begin
            mArmed = 1'b0;
        end else if (!v) begin
            mArmed = 1'b1;
            mPos   = 0;
        end else begin
            if (mPos < 24) mDest[mPos] = d;
            eo = mArmed && (mPos >= 56) && destOk();
            mPos++;
        end
        expOv.push_back(eo);
        expOd.push_back(eo ? d : 2'b00);
        @(posedge clk);
        #1;
        capOv.push_back(axiov);
        capOd.push_back(axiod);
        if (axiov === 1'b1) begin
            if (firstIdx < 0) firstIdx = capOv.size() - 1;
            payQ.push_back(axiod);
        end
    endtask

    task automatic makeFrame(input logic [47:0] dst, input int nPay);
        logic [7:0] b;
        fr.delete();
        for (int i = 0; i < 6; i++) begin
            b = dst[47-8*i -: 8];
            for (int j = 0; j < 4; j++) fr.push_back(b[2*j +: 2]);
        end
        repeat (32) fr.push_back(2'($urandom));
        repeat (nPay) fr.push_back(2'($urandom));
    endtask

    task automatic sendFrame();
        foreach (fr[i]) stepCycle(1'b0, 1'b1, fr[i]);
    endtask

    task automatic test_reset();
        clearCap();
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b1, 1'($urandom), 2'($urandom));
            checks++;
            if (axiov !== 1'b0 || axiod !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got axiov=%b axiod=%b, want axiov=0 axiod=00", i, axiov, axiod);
            end
        end
        stepCycle(1'b0, 1'b0, 2'b00);
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_unicast();
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        clearCap();
        makeFrame(MAC, 0);
        foreach (want[i]) fr.push_back(want[i]);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL unicast cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
        checks++;
        if (payQ.size() !== 4 || firstIdx !== 56) begin
            errors++;
            $display("[TB] FAIL unicast_burst: got %0d dibits starting at cycle %0d, want 4 starting at 56", payQ.size(), firstIdx);
        end
        for (int i = 0; i < 4 && i < payQ.size(); i++) begin
            checks++;
            if (payQ[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL unicast_data %0d: got %b, want %b", i, payQ[i], want[i]);
            end
        end
    endtask

    task automatic test_broadcast();
        clearCap();
        makeFrame(BCAST, 8);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 8) begin
            errors++;
            $display("[TB] FAIL broadcast_count: got %0d dibits, want 8", payQ.size());
        end
        makeFrame(BCAST, 8);
        fr[5] = 2'b00;
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 8) begin
            errors++;
            $display("[TB] FAIL bad_dest_count: got %0d total dibits, want 8", payQ.size());
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL broadcast cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_runt();
        clearCap();
        makeFrame(MAC, 0);
        while (fr.size() > 40) void'(fr.pop_back());
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        makeFrame(MAC, 3);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 3) begin
            errors++;
            $display("[TB] FAIL runt_count: got %0d dibits, want 3", payQ.size());
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL runt cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clearCap();
        makeFrame(MAC, 6);
        foreach (fr[i]) stepCycle(1'(i < 10), 1'b1, fr[i]);
        checks++;
        if (payQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL reset_release_count: got %0d dibits, want 0", payQ.size());
        end
        stepCycle(1'b0, 1'b0, 2'b00);
        makeFrame(MAC, 5);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 5) begin
            errors++;
            $display("[TB] FAIL reset_release_next: got %0d dibits, want 5", payQ.size());
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL reset_midframe cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_reset_payload();
        clearCap();
        makeFrame(MAC, 20);
        foreach (fr[i]) stepCycle(1'(i == 61), 1'b1, fr[i]);
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 5) begin
            errors++;
            $display("[TB] FAIL reset_payload_count: got %0d dibits, want 5", payQ.size());
        end
        makeFrame(MAC, 4);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        checks++;
        if (payQ.size() !== 9) begin
            errors++;
            $display("[TB] FAIL reset_payload_next: got %0d total dibits, want 9", payQ.size());
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL reset_payload cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev   = -1;
        int gapLen = -1;
        clearCap();
        makeFrame(MAC, 6);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        makeFrame(MAC, 6);
        sendFrame();
        stepCycle(1'b0, 1'b0, 2'b00);
        foreach (capOv[i]) begin
            if (capOv[i] === 1'b1) begin
                if (prev >= 0 && i - prev - 1 > 0) gapLen = i - prev - 1;
                prev = i;
            end
        end
        checks++;
        if (payQ.size() !== 12 || gapLen < 57) begin
            errors++;
            $display("[TB] FAIL back_to_back: got %0d dibits with gap %0d, want 12 with gap >= 57", payQ.size(), gapLen);
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    task automatic test_random();
        clearCap();
        for (int f = 0; f < 30; f++) begin
            int          sel   = $urandom_range(0, 3);
            int          rstAt = -1;
            logic [47:0] addr;
            case (sel)
                0:       addr = MAC;
                1:       addr = BCAST;
                2:       addr = {16'($urandom), 32'($urandom)};
                default: begin
                    addr = MAC;
                    addr[$urandom_range(0, 47)] ^= 1'b1;
                end
            endcase
            makeFrame(addr, $urandom_range(0, 20));
            if ($urandom_range(0, 4) == 0) begin
                int len = $urandom_range(1, 55);
                while (fr.size() > len) void'(fr.pop_back());
            end
            if ($urandom_range(0, 7) == 0) rstAt = $urandom_range(0, fr.size() - 1);
            foreach (fr[i]) stepCycle(1'(i == rstAt), 1'b1, fr[i]);
            repeat ($urandom_range(1, 3)) stepCycle(1'b0, 1'b0, 2'($urandom));
        end
        foreach (capOv[i]) begin
            checks++;
            if (capOv[i] !== expOv[i] || capOd[i] !== expOd[i]) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got axiov=%b axiod=%b, want axiov=%b axiod=%b", i, capOv[i], capOd[i], expOv[i], expOd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_runt();
        test_reset_midframe();
        test_reset_payload();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
